// File: rtl/io_pkg.sv
// Shared definitions for the GPIO pad controller: default sizes and the
// warm-up state machine encoding.
package io_pkg;

   localparam int NPADS_DEF       = 22;
   localparam int SYNC_STAGES_DEF = 2;

   // FILL: synchronizer and edge-delay flops still hold reset data.
   // RUN : edge detection is live.
   typedef enum logic [0:0] {
      WARM_FILL = 1'b0,
      WARM_RUN  = 1'b1
   } warm_state_e;

   // Counter width able to hold 0 .. stages (the last FILL count).
   function automatic int warm_cnt_width(input int stages);
      return $clog2(stages + 2);
   endfunction

endpackage

// File: rtl/io_sync.sv
// Multi-stage flop synchronizer for asynchronous pad inputs.
// The output is the last stage; latency is STAGES clock cycles.
module io_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];

   // Shift chain: stage 0 samples the pad, each later stage takes its predecessor.
   always_comb begin
      sync_d[0] = d;
      for (int s = 1; s < STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   // Synchronizer flops, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            sync_q[s] <= {WIDTH{1'b0}};
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/io_gpio_ctrl.sv
// GPIO pad controller: registered output/special-function mux, input
// synchronization, edge-triggered sticky interrupt pending bits and a
// warm-up phase that suppresses edges caused by reset-cleared flops.
module io_gpio_ctrl
   import io_pkg::*;
#(
   parameter int NPADS       = NPADS_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NPADS-1:0] gpio_oe,
   input  logic [NPADS-1:0] gpio_fn,
   input  logic [NPADS-1:0] gpio_out,
   input  logic [NPADS-1:0] sf_out,
   input  logic [NPADS-1:0] sf_oe,
   input  logic [NPADS-1:0] pad_in,
   output logic [NPADS-1:0] pad_out,
   output logic [NPADS-1:0] pad_oe,
   output logic [NPADS-1:0] gpio_in,
   input  logic [NPADS-1:0] irq_rise_en,
   input  logic [NPADS-1:0] irq_fall_en,
   input  logic [NPADS-1:0] irq_clr,
   output logic [NPADS-1:0] irq_pending,
   output logic             irq
);

   localparam int               CNT_W     = warm_cnt_width(SYNC_STAGES);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(SYNC_STAGES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [NPADS-1:0] pad_out_q, pad_out_d;
   logic [NPADS-1:0] pad_oe_q, pad_oe_d;
   logic [NPADS-1:0] gin_dly_q, gin_dly_d;
   logic [NPADS-1:0] pend_q, pend_d;
   logic             irq_q, irq_d;
   warm_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [NPADS-1:0] gpio_in_s;
   logic [NPADS-1:0] rise_s;
   logic [NPADS-1:0] fall_s;
   logic [NPADS-1:0] elig_s;
   logic [NPADS-1:0] set_s;
   logic             detect_en_s;

   io_sync #(
      .WIDTH  (NPADS),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pad_in),
      .q     (gpio_in_s)
   );

   // Per-pad drive selection between GPIO and special function.
   always_comb begin
      pad_out_d = (gpio_fn & sf_out) | (~gpio_fn & gpio_out);
      pad_oe_d  = (gpio_fn & sf_oe)  | (~gpio_fn & gpio_oe);
   end

   // Warm-up next state: stay in FILL until the pipeline has flushed reset data.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         WARM_FILL: begin
            if (cnt_q == FILL_LAST) begin
               state_d = WARM_RUN;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         WARM_RUN: begin
            state_d = WARM_RUN;
         end
         default: begin
            state_d = WARM_FILL;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Warm-up outputs: edges are honoured only once running.
   always_comb begin
      detect_en_s = 1'b0;
      case (state_q)
         WARM_FILL: detect_en_s = 1'b0;
         WARM_RUN:  detect_en_s = 1'b1;
         default:   detect_en_s = 1'b0;
      endcase
   end

   // Edge detection, eligibility and sticky pending update (set beats clear).
   always_comb begin
      gin_dly_d = gpio_in_s;
      rise_s    = gpio_in_s & ~gin_dly_q;
      fall_s    = ~gpio_in_s & gin_dly_q;
      elig_s    = ~gpio_fn & ~gpio_oe;
      if (detect_en_s) begin
         set_s = elig_s & ((rise_s & irq_rise_en) | (fall_s & irq_fall_en));
      end else begin
         set_s = {NPADS{1'b0}};
      end
      pend_d = (pend_q & ~irq_clr) | set_s;
      irq_d  = |pend_q;
   end

   // All controller state; reset forces pads to input and discards events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_out_q <= {NPADS{1'b0}};
         pad_oe_q  <= {NPADS{1'b0}};
         gin_dly_q <= {NPADS{1'b0}};
         pend_q    <= {NPADS{1'b0}};
         irq_q     <= 1'b0;
         state_q   <= WARM_FILL;
         cnt_q     <= {CNT_W{1'b0}};
      end else begin
         pad_out_q <= pad_out_d;
         pad_oe_q  <= pad_oe_d;
         gin_dly_q <= gin_dly_d;
         pend_q    <= pend_d;
         irq_q     <= irq_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
      end
   end

   assign pad_out     = pad_out_q;
   assign pad_oe      = pad_oe_q;
   assign gpio_in     = gpio_in_s;
   assign irq_pending = pend_q;
   assign irq         = irq_q;

endmodule

// File: tb/tb_io_gpio_ctrl.sv
// Directed plus randomized bench for io_gpio_ctrl with a history-based
// reference model of the pad controller.
module tb_io_gpio_ctrl;

   localparam int NP = 22;
   localparam int S  = 2;
   localparam logic [NP-1:0] ALL1 = {NP{1'b1}};
   localparam logic [NP-1:0] ALL0 = {NP{1'b0}};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NP-1:0] gpio_oe = '0, gpio_fn = '0, gpio_out = '0;
   logic [NP-1:0] sf_out = '0, sf_oe = '0, pad_in = '0;
   logic [NP-1:0] irq_rise_en = '0, irq_fall_en = '0, irq_clr = '0;
   logic [NP-1:0] pad_out, pad_oe, gpio_in, irq_pending;
   logic          irq;

   int total = 0;
   int bad   = 0;

   // Reference model: samp[k-1] is pad_in as sampled at rising edge k after reset release.
   logic [NP-1:0] samp [$];
   logic [NP-1:0] m_pend = '0, m_po = '0, m_poe = '0, m_gin = '0;
   logic          m_irq = 1'b0;

   io_gpio_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .gpio_oe(gpio_oe), .gpio_fn(gpio_fn), .gpio_out(gpio_out),
      .sf_out(sf_out), .sf_oe(sf_oe), .pad_in(pad_in),
      .pad_out(pad_out), .pad_oe(pad_oe), .gpio_in(gpio_in),
      .irq_rise_en(irq_rise_en), .irq_fall_en(irq_fall_en), .irq_clr(irq_clr),
      .irq_pending(irq_pending), .irq(irq)
   );

   always #5 clk = ~clk;

   // Synchronized input value seen after edge k: the pad value from S-1 edges earlier.
   function automatic logic [NP-1:0] gin(input int k);
      if (k >= S) return samp[k-S];
      return '0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("pad_out", 32'(pad_out), 32'(m_po));
      chk("pad_oe", 32'(pad_oe), 32'(m_poe));
      chk("gpio_in", 32'(gpio_in), 32'(m_gin));
      chk("irq_pending", 32'(irq_pending), 32'(m_pend));
      chk("irq", 32'(irq), 32'(m_irq));
   endtask

   // One clock: capture the inputs the edge will see, advance the model, compare.
   task automatic step();
      logic [NP-1:0] c_fn, c_oe, c_go, c_so, c_soe, c_pad, c_ren, c_fen, c_clr, nw, od, st;
      logic          c_rst;
      int            n;
      c_fn = gpio_fn; c_oe = gpio_oe; c_go = gpio_out; c_so = sf_out; c_soe = sf_oe;
      c_pad = pad_in; c_ren = irq_rise_en; c_fen = irq_fall_en; c_clr = irq_clr;
      c_rst = rst_n;
      @(posedge clk);
      if (!c_rst) begin
         samp.delete();
         m_pend = '0; m_irq = 1'b0; m_po = '0; m_poe = '0; m_gin = '0;
      end else begin
         m_irq = |m_pend;
         samp.push_back(c_pad);
         n = samp.size();
         st = '0;
         // Edges count only once S+1 warm-up edges have passed.
         if (n >= S + 2) begin
            nw = gin(n - 1);
            od = gin(n - 2);
            st = ~c_fn & ~c_oe & ((nw & ~od & c_ren) | (~nw & od & c_fen));
         end
         m_pend = (m_pend & ~c_clr) | st;
         m_po   = c_fn ? c_so  : c_go;
         m_po   = (c_fn & c_so)  | (~c_fn & c_go);
         m_poe  = (c_fn & c_soe) | (~c_fn & c_oe);
         m_gin  = gin(n);
      end
      #1;
      check_model();
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   initial begin
      // Reset state.
      #1;
      chk("reset_pad_oe", 32'(pad_oe), 32'(ALL0));
      chk("reset_pend", 32'(irq_pending), 32'(ALL0));
      steps(2);
      rst_n = 1'b1;
      steps(6);

      // Output mux.
      gpio_fn = 22'h000001; sf_out = 22'h000001; sf_oe = 22'h000001;
      gpio_oe = 22'h000002; gpio_out = 22'h000002;
      step();
      chk("mux_pad_oe", 32'(pad_oe), 32'h3);
      chk("mux_pad_out", 32'(pad_out), 32'h3);
      gpio_fn = '0; sf_out = '0; sf_oe = '0; gpio_oe = '0; gpio_out = '0;
      step();

      // Rising edge on pad 3.
      irq_rise_en = 22'h000008;
      pad_in[3] = 1'b1;
      steps(2);
      chk("rise_gpio_in3", 32'(gpio_in[3]), 32'h1);
      chk("rise_irq_early", 32'(irq), 32'h0);
      step();
      chk("rise_pend", 32'(irq_pending), 32'h8);
      step();
      chk("rise_irq", 32'(irq), 32'h1);

      // Clear racing a new rising edge: set must win.
      pad_in[3] = 1'b0;
      steps(3);
      pad_in[3] = 1'b1;
      steps(2);
      irq_clr = 22'h000008;
      step();
      irq_clr = '0;
      chk("race_pend", 32'(irq_pending), 32'h8);
      irq_clr = 22'h000008;
      step();
      irq_clr = '0;
      chk("clr_pend", 32'(irq_pending), 32'h0);
      step();
      chk("clr_irq", 32'(irq), 32'h0);

      // Eligibility: output-direction or special-function pads never interrupt.
      pad_in[5] = 1'b1;
      steps(4);
      gpio_oe[5] = 1'b1; irq_fall_en[5] = 1'b1; pad_in[5] = 1'b0;
      steps(4);
      chk("elig_oe", 32'(irq_pending), 32'h0);
      gpio_oe[5] = 1'b0; gpio_fn[5] = 1'b1; pad_in[5] = 1'b1;
      steps(4);
      pad_in[5] = 1'b0;
      steps(4);
      chk("elig_fn", 32'(irq_pending), 32'h0);
      gpio_fn[5] = 1'b0; irq_fall_en = '0;

      // Sticky pending: disabling the enable keeps the bit.
      pad_in[3] = 1'b0; steps(3);
      pad_in[3] = 1'b1; steps(3);
      irq_rise_en = '0; gpio_oe[3] = 1'b1;
      steps(2);
      chk("sticky_pend", 32'(irq_pending), 32'h8);
      gpio_oe[3] = 1'b0;

      // Asynchronous reset mid-operation with pad 3 still high.
      irq_rise_en = 22'h000008;
      rst_n = 1'b0;
      #1;
      chk("async_pend", 32'(irq_pending), 32'h0);
      chk("async_irq", 32'(irq), 32'h0);
      chk("async_gpio_in", 32'(gpio_in), 32'h0);
      chk("async_pad_oe", 32'(pad_oe), 32'h0);
      steps(2);
      rst_n = 1'b1;
      steps(8);
      chk("postrst_pend", 32'(irq_pending), 32'h0);

      // Warm-up: all pads held high through reset with all rise enables on.
      gpio_oe = '0; gpio_fn = '0;
      pad_in = ALL1; irq_rise_en = ALL1;
      rst_n = 1'b0;
      steps(2);
      rst_n = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         step();
         chk("warm_pend", 32'(irq_pending), 32'h0);
         chk("warm_irq", 32'(irq), 32'h0);
         if (c >= 2) chk("warm_gpio_in", 32'(gpio_in), 32'(ALL1));
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         pad_in      = pad_in ^ NP'($urandom & $urandom & $urandom);
         gpio_out    = NP'($urandom);
         sf_out      = NP'($urandom);
         sf_oe       = NP'($urandom);
         irq_clr     = NP'($urandom & $urandom & $urandom);
         if (c % 40 == 0) begin
            gpio_oe     = NP'($urandom & $urandom);
            gpio_fn     = NP'($urandom & $urandom);
            irq_rise_en = NP'($urandom);
            irq_fall_en = NP'($urandom);
         end
         if (c == 300 || c == 301) rst_n = 1'b0;
         else rst_n = 1'b1;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_gpio_ctrl.md
IO_GPIO_CTRL -- requirements
Module: io_gpio_ctrl

Interface
REQ-001 Parameter: NPADS, default 22, number of pads handled.
REQ-002 Parameter: SYNC_STAGES, default 2, input synchronizer depth (minimum 2).
REQ-003 Port: clk  in  1  single system clock; all state on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: gpio_oe  in  NPADS  direction from the IO register file (1 = output).
REQ-006 Port: gpio_fn  in  NPADS  pad function from the IO register file (0 = gpio, 1 = special function).
REQ-007 Port: gpio_out  in  NPADS  GPIO output data.
REQ-008 Port: sf_out, sf_oe  in  NPADS each  special-function output data and enable.
REQ-009 Port: pad_in  in  NPADS  asynchronous pad input.
REQ-010 Port: pad_out, pad_oe  out  NPADS each  registered pad drive and enable.
REQ-011 Port: gpio_in  out  NPADS  synchronized pad input, all pads.
REQ-012 Port: irq_rise_en, irq_fall_en  in  NPADS each  per-pad edge interrupt enables.
REQ-013 Port: irq_clr  in  NPADS  one-cycle clear strobe per pending bit.
REQ-014 Port: irq_pending  out  NPADS  latched edge events.
REQ-015 Port: irq  out  1  registered OR of irq_pending.

Function
REQ-016 Output mux per pad i: fn=0 -> (pad_out, pad_oe) = (gpio_out, gpio_oe); fn=1 -> (sf_out, sf_oe); registered; latency 1 cycle.
REQ-017 pad_in passes through SYNC_STAGES flops; gpio_in is the last stage; pad_in to gpio_in latency = SYNC_STAGES cycles.
REQ-018 Edge detect compares gpio_in with a one-cycle-delayed copy: rise = new&~old, fall = ~new&old.
REQ-019 Pad i is interrupt-eligible only when gpio_fn[i]=0 and gpio_oe[i]=0.
REQ-020 Set: irq_pending[i] sets on an eligible, enabled edge; pad_in step to irq_pending high = SYNC_STAGES+1 cycles.
REQ-021 Clear: irq_clr[i]=1 clears irq_pending[i] next cycle; a set and a clear in the same cycle -> set wins.
REQ-022 Pending bits are sticky: disabling the enable or changing fn/oe does not clear them.
REQ-023 irq = |irq_pending, registered; one cycle after irq_pending changes.
REQ-024 Warm-up FSM: states FILL -> RUN; FILL counts SYNC_STAGES+1 cycles after reset release, edges ignored; RUN detects edges; leaves RUN only on reset.
REQ-025 A pad held high through reset causes no pending bit after release.

Reset
REQ-026 rst_n low asynchronously sets pad_out=0, pad_oe=0 (all pads input), gpio_in=0, synchronizer and delay flops=0, irq_pending=0, irq=0, FSM=FILL with counter 0.
REQ-027 Reset asserted mid-operation discards pending events immediately; no edge from pre-reset state is reported after release.

Structure
REQ-028 NPADS default, SYNC_STAGES default and FSM state encodings reside in shared package io_pkg.
REQ-029 The synchronizer is sub-module io_sync (width, stages parameters, async active-low reset), instantiated once, NPADS wide.
REQ-030 No combinational path from any input to any output.

Verification
REQ-031 Mux: fn=0x000001, sf_out=0x000001, sf_oe=0x000001, gpio_oe=0x000002, gpio_out=0x000002 -> next cycle pad_oe=0x000003, pad_out=0x000003.
REQ-032 Rise: oe=fn=0, rise_en[3]=1, pad_in[3] 0->1 in RUN -> gpio_in[3]=1 after 2 cycles, irq_pending=0x000008 after 3, irq=1 after 4.
REQ-033 Clear race: irq_clr[3] pulsed in the same cycle as a new rising edge on pad 3 -> irq_pending[3] stays 1; clear alone -> 0 next cycle, irq=0 the cycle after.
REQ-034 Eligibility: fall_en[5]=1, gpio_oe[5]=1, pad_in[5] 1->0 -> irq_pending stays 0; same with gpio_fn[5]=1 -> stays 0.
REQ-035 Warm-up: pad_in=0x3FFFFF, rise_en=0x3FFFFF, rst_n released -> irq_pending=0 and irq=0 for 10 cycles, gpio_in=0x3FFFFF from cycle 2.
REQ-036 Reset mid-operation: irq_pending=0x000008, rst_n pulsed low asynchronously -> all outputs 0 immediately, irq_pending=0 after release.
